// File: rtl/mul_pkg.sv
// Shared opcode and multiplier-mode encodings for the RV32M multiply stage.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic MODE_U = 1'b0;
  localparam logic MODE_S = 1'b1;

endpackage

// File: rtl/mul32.sv
// Combinational 32x32 multiplier core producing the full 64-bit product.
// mode_i selects signed (both operands sign-extended) or unsigned operands.
module mul32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mode_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  // Extending to 64 bits makes the truncated product exact for either mode.
  assign a_ext = {{32{mode_i & a_i[31]}}, a_i};
  assign b_ext = {{32{mode_i & b_i[31]}}, b_i};
  assign prod  = a_ext * b_ext;

  assign lo_o = prod[31:0];
  assign hi_o = prod[63:32];

endmodule

// File: rtl/mul_issue_stage.sv
// Two-stage RV32M multiply: S1 registers operands, S2 registers the selected result word.
// Latency 2 cycles, 1 request/cycle; in_ready depends on out_ready, never on in_valid.
module mul_issue_stage
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic        s2_free;
  logic        s1_adv;
  logic        in_fire;
  logic        mul_mode;
  logic [31:0] mul_lo;
  logic [31:0] mul_hi;
  logic [31:0] res_sel;

  assign s2_free  = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_free;
  assign in_ready = ~s1_valid_q | s1_adv;
  assign in_fire  = in_valid & in_ready;

  assign mul_mode = (s1_op_q == OP_MUL || s1_op_q == OP_MULH) ? MODE_S : MODE_U;

  mul32 u_mul32 (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .mode_i (mul_mode),
    .lo_o   (mul_lo),
    .hi_o   (mul_hi)
  );

  // MULHSU runs unsigned; a negative rs1 over-counts by rs2 * 2^32, removed from the high word.
  always_comb begin
    res_sel = mul_lo;
    case (s1_op_q)
      OP_MULH, OP_MULHU: res_sel = mul_hi;
      OP_MULHSU:         res_sel = mul_hi - (s1_a_q[31] ? s1_b_q : 32'd0);
      default:           res_sel = mul_lo;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_res_d   = res_sel;
      s2_tag_d   = s1_tag_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_MUL;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Scoreboard bench for mul_issue_stage: directed vectors, LFSR stream, backpressure, mid-op reset.
module tb_mul_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_pop = 0;

  mul_issue_stage #(.TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", nm, act, want);
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    case (op)
      2'b00:   p = $signed(sa) * $signed(sb);
      2'b01:   p = $signed(sa) * $signed(sb);
      2'b10:   p = $signed(sa) * $signed(zb);
      default: p = $unsigned(za) * $unsigned(zb);
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: every output transfer is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got res=%h tag=%0d expected=none", out_res, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("out_res", 64'(out_res), 64'(e.res));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          n_pop++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] want, output int waits);
    logic r;
    exp_t e;
    waits    = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
      if (waits > 50) begin
        n_chk++;
        $display("FAIL accept_timeout: got no accept expected accept tag=%0d", tag);
        break;
      end
    end
    if (r) begin
      e.res = want;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic lat_check(input string nm);
    @(negedge clk);
    chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] want, input string nm);
    int w;
    send(op, a, b, tag, want, w);
    in_valid = 1'b0;
    lat_check(nm);
  endtask

  initial begin
    int          w;
    int          acc;
    int          pops0;
    logic        held;
    logic        r;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;
    logic [31:0] lfsr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] bp_a[2];
    logic [31:0] bp_want[2];
    exp_t        e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    directed(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, "mul");
    directed(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, "mulh");
    directed(2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, "mulhu_min");
    directed(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, "mulhsu");
    directed(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, "mulhu_max");

    // Streaming: back-to-back requests must each be taken without a stall.
    lfsr  = 32'hACE1_2345;
    pops0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      a    = lfsr;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      b    = lfsr ^ {lfsr[15:0], lfsr[31:16]};
      send(2'(i), a, b, 5'(i), ref_res(2'(i), a, b), w);
      chk("stream_no_stall", 64'(w), 64'd0);
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("stream_count", 64'(n_pop - pops0), 64'd16);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: consumer stalls, exactly two requests fit.
    bp_a[0]    = 32'd100;
    bp_a[1]    = 32'hFFFF_FFFE;
    bp_want[0] = 32'd300;
    bp_want[1] = 32'hFFFF_FFFA;
    out_ready  = 1'b0;
    acc        = 0;
    held       = 1'b0;
    hold_res   = '0;
    hold_tag   = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_a     = (acc < 2) ? bp_a[acc] : 32'd9;
      in_b     = 32'd3;
      in_tag   = 5'(20 + acc);
      @(negedge clk);
      if (out_valid) begin
        if (!held) begin
          held     = 1'b1;
          hold_res = out_res;
          hold_tag = out_tag;
        end else begin
          chk("bp_res_stable", 64'(out_res), 64'(hold_res));
          chk("bp_tag_stable", 64'(out_tag), 64'(hold_tag));
        end
      end
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        e.res = (acc < 2) ? bp_want[acc] : 32'd27;
        e.tag = 5'(20 + acc);
        exp_q.push_back(e);
        acc++;
      end
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with both stages full.
    out_ready = 1'b0;
    send(2'b00, 32'd5, 32'd5, 5'd30, 32'd25, w);
    send(2'b00, 32'd6, 32'd6, 5'd31, 32'd36, w);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_res", 64'(out_res), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("postrst_idle", 64'(out_valid), 64'd0);
    directed(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'hFFFF_FFFF, "postrst");

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
